// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single shared memory port with one outstanding transaction.
// Define MEM_ARB_RR_EN to use round-robin on simultaneous requests; the default gives LSU fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  input  logic        ifu_flush,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_we,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_req_ready,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e      state_q;
  owner_e      owner_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        mem_req_valid_q;
  logic        ifu_rvalid_q;
  logic        lsu_rvalid_q;
  logic [31:0] ifu_rdata_q;
  logic [31:0] lsu_rdata_q;
  logic        drop_q;
  logic        drop_d;
  logic        grant_ifu;
  logic        grant_lsu;
`ifdef MEM_ARB_RR_EN
  // Reset value 1 makes IFU the winner of the first tie.
  logic        last_lsu_q;
`endif

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = ~last_lsu_q;
        grant_ifu = last_lsu_q;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (ifu_flush && (grant_ifu || (state_q != IDLE && owner_q == OWN_IFU))) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IFU;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      mem_req_valid_q <= 1'b0;
      ifu_rvalid_q    <= 1'b0;
      lsu_rvalid_q    <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rdata_q     <= '0;
      drop_q          <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_lsu_q      <= 1'b1;
`endif
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            owner_q         <= OWN_LSU;
            addr_q          <= lsu_req_addr;
            we_q            <= lsu_req_we;
            wdata_q         <= lsu_req_wdata;
            wstrb_q         <= lsu_req_wstrb;
            drop_q          <= 1'b0;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end else if (grant_ifu) begin
            owner_q         <= OWN_IFU;
            addr_q          <= ifu_req_addr;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            drop_q          <= drop_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end
`ifdef MEM_ARB_RR_EN
          if (grant_lsu || grant_ifu) begin
            last_lsu_q <= grant_lsu;
          end
`endif
        end
        ISSUE: begin
          drop_q <= drop_d;
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          drop_q <= drop_d;
          if (mem_resp_valid) begin
            state_q <= RESP;
            if (owner_q == OWN_LSU) begin
              lsu_rdata_q  <= we_q ? '0 : mem_rdata;
              lsu_rvalid_q <= 1'b1;
            end else begin
              ifu_rdata_q  <= mem_rdata;
              ifu_rvalid_q <= ~drop_d;
            end
          end
        end
        RESP: begin
          drop_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  // A flush landing in RESP still has to cancel the pulse already registered.
  assign ifu_rvalid    = ifu_rvalid_q & ~ifu_flush;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rvalid    = lsu_rvalid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected bus requests and responses,
// a negedge monitor pops and compares them; a small memory model answers the shared port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_flush;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_req_ready;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        arb_busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_flush(ifu_flush), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_mem_q[$];
  logic [31:0] exp_ifu_q[$];
  logic [31:0] exp_lsu_q[$];
  int stall_left = 0;
  int resp_delay = 0;
  logic [3:0] exp_order;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_req(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got addr/we/wdata/wstrb %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event expected none", name);
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_lookup = 32'h0000_0413;
      32'h8000_0004: mem_lookup = 32'h0010_0093;
      32'h0000_1000: mem_lookup = 32'hDEAD_BEEF;
      32'h0000_2000: mem_lookup = 32'hCAFE_F00D;
      default:       mem_lookup = 32'h0BAD_F00D;
    endcase
  endfunction

  // Memory model: stall_left cycles of backpressure, then a response resp_delay cycles after WAIT entry.
  initial begin
    logic        pending;
    logic [31:0] paddr;
    int          wcnt;
    pending = 1'b0;
    paddr = '0;
    wcnt = 0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_rdata = '0;
      mem_req_ready = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (wcnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata = mem_lookup(paddr);
            pending = 1'b0;
          end else begin
            wcnt--;
          end
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mem_req_ready = 1'b1;
            pending = 1'b1;
            paddr = mem_addr;
            wcnt = resp_delay;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk_bit("ready_exclusive", ifu_req_ready & lsu_req_ready, 1'b0);
    chk_bit("ready_outside_idle", arb_busy & (ifu_req_ready | lsu_req_ready), 1'b0);
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) unexpected("mem_req_unexpected");
        else chk_req("mem_req", {mem_addr, mem_we, mem_wdata, mem_wstrb}, exp_mem_q.pop_front());
      end
      if (ifu_rvalid) begin
        if (exp_ifu_q.size() == 0) unexpected("ifu_rvalid_unexpected");
        else chk_word("ifu_rdata", ifu_rdata, exp_ifu_q.pop_front());
      end
      if (lsu_rvalid) begin
        if (exp_lsu_q.size() == 0) unexpected("lsu_rvalid_unexpected");
        else chk_word("lsu_rdata", lsu_rdata, exp_lsu_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (arb_busy && n < 30) begin
      tick();
      n++;
    end
    chk_bit({name, "_idle_timeout"}, n < 30, 1'b1);
  endtask

  task automatic no_ifu_rvalid_until_idle(input string name);
    int n = 0;
    while (arb_busy && n < 30) begin
      #2;
      chk_bit(name, ifu_rvalid, 1'b0);
      tick();
      n++;
    end
    chk_bit({name, "_idle_timeout"}, n < 30, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0000;
    ifu_flush = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_1000;
    lsu_req_we = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wstrb = '0;
    repeat (2) @(posedge clk);
    #3;
    chk_bit("rst_outputs_zero", |{ifu_req_ready, ifu_rvalid, ifu_rdata, lsu_req_ready, lsu_rvalid,
            lsu_rdata, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, arb_busy}, 1'b0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // single fetch, minimum latency
    exp_mem_q.push_back({32'h8000_0000, 1'b0, 32'h0, 4'h0});
    exp_ifu_q.push_back(32'h0000_0413);
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0000;
    #2;
    chk_bit("t1_c0_ifu_ready", ifu_req_ready, 1'b1);
    chk_bit("t1_c0_lsu_ready", lsu_req_ready, 1'b0);
    tick();
    ifu_req_valid = 1'b0;
    #2;
    chk_bit("t1_c1_mem_valid", mem_req_valid, 1'b1);
    chk_bit("t1_c1_busy", arb_busy, 1'b1);
    tick();
    #2;
    chk_bit("t1_c2_mem_valid", mem_req_valid, 1'b0);
    chk_bit("t1_c2_rvalid", ifu_rvalid, 1'b0);
    tick();
    #2;
    chk_bit("t1_c3_rvalid", ifu_rvalid, 1'b1);
    chk_word("t1_c3_rdata", ifu_rdata, 32'h0000_0413);
    tick();
    #2;
    chk_bit("t1_c4_rvalid", ifu_rvalid, 1'b0);
    chk_bit("t1_c4_busy", arb_busy, 1'b0);
    tick();

    // tie: LSU first, IFU granted the cycle after LSU rvalid
    exp_mem_q.push_back({32'h0000_1000, 1'b0, 32'h0, 4'h0});
    exp_mem_q.push_back({32'h8000_0004, 1'b0, 32'h0, 4'h0});
    exp_lsu_q.push_back(32'hDEAD_BEEF);
    exp_ifu_q.push_back(32'h0010_0093);
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_1000;
    #2;
    chk_bit("t2_tie_lsu_ready", lsu_req_ready, 1'b1);
    chk_bit("t2_tie_ifu_ready", ifu_req_ready, 1'b0);
    tick();
    lsu_req_valid = 1'b0;
    tick();
    tick();
    #2;
    chk_bit("t2_resp_lsu_rvalid", lsu_rvalid, 1'b1);
    chk_bit("t2_resp_ifu_ready", ifu_req_ready, 1'b0);
    tick();
    #2;
    chk_bit("t2_after_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    wait_idle("t2");
    tick();

    // backpressure with a store
    stall_left = 3;
    exp_mem_q.push_back({32'h0000_2000, 1'b1, 32'h1122_3344, 4'h3});
    exp_lsu_q.push_back(32'h0000_0000);
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_2000;
    lsu_req_we = 1'b1;
    lsu_req_wdata = 32'h1122_3344;
    lsu_req_wstrb = 4'h3;
    #2;
    chk_bit("t3_lsu_ready", lsu_req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      lsu_req_valid = 1'b0;
      lsu_req_addr = 32'h0000_FFFF;
      lsu_req_we = 1'b0;
      lsu_req_wdata = '0;
      lsu_req_wstrb = '0;
      #2;
      chk_bit($sformatf("t3_stall%0d_mem_valid", i), mem_req_valid, 1'b1);
      chk_req($sformatf("t3_stall%0d_fields", i), {mem_addr, mem_we, mem_wdata, mem_wstrb},
              {32'h0000_2000, 1'b1, 32'h1122_3344, 4'h3});
      chk_bit($sformatf("t3_stall%0d_busy", i), arb_busy, 1'b1);
    end
    tick();
    #2;
    chk_bit("t3_wait_mem_valid", mem_req_valid, 1'b0);
    wait_idle("t3");
    tick();

    // flush during WAIT: bus completes, no IFU rvalid
    resp_delay = 2;
    exp_mem_q.push_back({32'h8000_0008, 1'b0, 32'h0, 4'h0});
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0008;
    #2;
    chk_bit("t4a_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    tick();
    ifu_flush = 1'b1;
    tick();
    ifu_flush = 1'b0;
    no_ifu_rvalid_until_idle("t4a_no_rvalid");
    chk_word("t4a_bus_completed", exp_mem_q.size(), 32'd0);
    resp_delay = 0;
    tick();

    // flush in the accept cycle
    exp_mem_q.push_back({32'h8000_000C, 1'b0, 32'h0, 4'h0});
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_000C;
    ifu_flush = 1'b1;
    #2;
    chk_bit("t4b_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    ifu_flush = 1'b0;
    no_ifu_rvalid_until_idle("t4b_no_rvalid");
    tick();

    // flush while idle with no request, then a normal fetch
    ifu_flush = 1'b1;
    tick();
    ifu_flush = 1'b0;
    exp_mem_q.push_back({32'h8000_0000, 1'b0, 32'h0, 4'h0});
    exp_ifu_q.push_back(32'h0000_0413);
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0000;
    tick();
    ifu_req_valid = 1'b0;
    wait_idle("t4c");
    tick();

    // flush has no effect on an LSU transaction
    exp_mem_q.push_back({32'h0000_1000, 1'b0, 32'h0, 4'h0});
    exp_lsu_q.push_back(32'hDEAD_BEEF);
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_1000;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    ifu_flush = 1'b1;
    tick();
    #2;
    chk_bit("t4d_lsu_rvalid", lsu_rvalid, 1'b1);
    tick();
    ifu_flush = 1'b0;
    wait_idle("t4d");
    chk_word("t4d_lsu_q_empty", exp_lsu_q.size(), 32'd0);

    // continuous requests from both after reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    for (int g = 0; g < 4; g++) begin
      if (exp_order[g]) begin
        exp_mem_q.push_back({32'h0000_1000, 1'b0, 32'h0, 4'h0});
        exp_lsu_q.push_back(32'hDEAD_BEEF);
      end else begin
        exp_mem_q.push_back({32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_ifu_q.push_back(32'h0000_0413);
      end
    end
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_1000;
    lsu_req_we = 1'b0;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      #2;
      while (!(ifu_req_ready || lsu_req_ready) && n < 20) begin
        tick();
        #2;
        n++;
      end
      chk_bit($sformatf("t5_grant%0d_timeout", g), n < 20, 1'b1);
      chk_bit($sformatf("t5_grant%0d_is_lsu", g), lsu_req_ready, exp_order[g]);
      tick();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wait_idle("t5");
    tick();

    // reset during WAIT
    resp_delay = 3;
    exp_mem_q.push_back({32'h0000_2000, 1'b0, 32'h0, 4'h0});
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_2000;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    #2;
    chk_bit("t6_busy_in_wait", arb_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("t6_rst_outputs_zero", |{ifu_req_ready, ifu_rvalid, ifu_rdata, lsu_req_ready, lsu_rvalid,
            lsu_rdata, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, arb_busy}, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    resp_delay = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk_bit($sformatf("t6_no_lsu_rvalid%0d", i), lsu_rvalid, 1'b0);
    end

    // recovery fetch
    exp_mem_q.push_back({32'h8000_0004, 1'b0, 32'h0, 4'h0});
    exp_ifu_q.push_back(32'h0010_0093);
    tick();
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0004;
    tick();
    ifu_req_valid = 1'b0;
    wait_idle("t7");
    tick();
    tick();

    chk_word("end_mem_q_empty", exp_mem_q.size(), 32'd0);
    chk_word("end_ifu_q_empty", exp_ifu_q.size(), 32'd0);
    chk_word("end_lsu_q_empty", exp_lsu_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
